// File: rtl/pic_prio_pkg.sv
// Shared definitions for the pic_prio interrupt controller: EVB write-mask
// encodings, register addresses, CLAIM word layout and write-merge helpers.
package pic_prio_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
  localparam int ID_W   = 5;

  typedef enum logic [1:0] {
    EVB_MASK_DUMMY = 2'b00,
    EVB_MASK_L     = 2'b01,
    EVB_MASK_H     = 2'b10,
    EVB_MASK_W     = 2'b11
  } evb_mask_e;

  localparam logic [ADDR_W-1:0] ADDR_PEND     = 4'd0;
  localparam logic [ADDR_W-1:0] ADDR_MASK     = 4'd1;
  localparam logic [ADDR_W-1:0] ADDR_MODE     = 4'd2;
  localparam logic [ADDR_W-1:0] ADDR_POL      = 4'd3;
  localparam logic [ADDR_W-1:0] ADDR_CLAIM    = 4'd4;
  localparam logic [ADDR_W-1:0] ADDR_COMPLETE = 4'd5;
  localparam logic [ADDR_W-1:0] ADDR_INSV     = 4'd6;
  localparam logic [ADDR_W-1:0] ADDR_GPIO_OUT = 4'd7;
  localparam logic [ADDR_W-1:0] ADDR_GPIO_IN  = 4'd8;

  typedef struct packed {
    logic            valid;
    logic [25:0]     rsvd;
    logic [ID_W-1:0] id;
  } claim_t;

  // Byte-lane enables of a write; H and L both take their data from wr_data[15:0].
  function automatic logic [DATA_W-1:0] evb_bmask(input logic [1:0] m);
    case (m)
      EVB_MASK_W: evb_bmask = 32'hFFFF_FFFF;
      EVB_MASK_H: evb_bmask = 32'hFFFF_0000;
      EVB_MASK_L: evb_bmask = 32'h0000_FFFF;
      default:    evb_bmask = 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] evb_align(input logic [1:0] m, input logic [DATA_W-1:0] d);
    evb_align = (m == EVB_MASK_W) ? d : {d[15:0], d[15:0]};
  endfunction

  function automatic logic [DATA_W-1:0] evb_merge(input logic [DATA_W-1:0] old,
                                                  input logic [1:0] m,
                                                  input logic [DATA_W-1:0] d);
    evb_merge = (old & ~evb_bmask(m)) | (evb_align(m, d) & evb_bmask(m));
  endfunction

endpackage

// File: rtl/pic_prio_if.sv
// EVB command bus between a processor-side master and the pic_prio slave.
interface pic_prio_if;
  import pic_prio_pkg::*;

  logic              evb_cmd_request;
  logic [ADDR_W-1:0] evb_cmd_addr;
  logic [1:0]        evb_cmd_wr_mask;
  logic [DATA_W-1:0] evb_cmd_wr_data;
  logic              evb_cmd_finish;
  logic [DATA_W-1:0] evb_cmd_rd_data;

  modport master (
    output evb_cmd_request, evb_cmd_addr, evb_cmd_wr_mask, evb_cmd_wr_data,
    input  evb_cmd_finish, evb_cmd_rd_data
  );

  modport slave (
    input  evb_cmd_request, evb_cmd_addr, evb_cmd_wr_mask, evb_cmd_wr_data,
    output evb_cmd_finish, evb_cmd_rd_data
  );

endinterface

// File: rtl/pic_prio_enc.sv
// Priority select: lowest set index of req wins.
module pic_prio_enc
  import pic_prio_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] req,
  output logic             valid,
  output logic [ID_W-1:0]  id
);

  always_comb begin
    valid = |req;
    id    = '0;
    // Scan downward so the lowest set index is the last assignment.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) id = ID_W'(i);
    end
  end

endmodule

// File: rtl/pic_prio.sv
// Interrupt controller with edge/level capture, mask, claim/complete and a
// small GPIO block, configured over the EVB command bus.
module pic_prio
  import pic_prio_pkg::*;
#(
  parameter int          NUM_IRQ  = 32,
  parameter int          NUM_GPIO = 16,
  parameter logic [31:0] MASK_RST = 32'h0000_00FF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_IRQ-1:0]  int_src,
  output logic                mp_int,
  input  logic [NUM_GPIO-1:0] gpio_in,
  output logic [NUM_GPIO-1:0] gpio_out,
  pic_prio_if.slave           evb
);

  logic [NUM_IRQ-1:0] pend, mask, mode, pol, insv, act_d1;
  logic [NUM_IRQ-1:0] act, edge_set, elig, w1c_clr, claim_oh, cmp_clr, pend_nxt, insv_nxt;
  logic               enc_valid;
  logic [ID_W-1:0]    enc_id;
  logic [ID_W-1:0]    cmp_id;
  logic               fire, is_write;
  logic [1:0]         wmask;
  logic [DATA_W-1:0]  wdata, rdata;
  claim_t             claim_word;

  assign act      = int_src ^ pol;
  assign edge_set = act & ~act_d1 & mode;
  assign elig     = pend & mask & ~insv;

  pic_prio_enc #(.WIDTH(NUM_IRQ)) u_enc (
    .req   (elig),
    .valid (enc_valid),
    .id    (enc_id)
  );

  assign wmask    = evb.evb_cmd_wr_mask;
  assign wdata    = evb.evb_cmd_wr_data;
  assign cmp_id   = wdata[ID_W-1:0];
  assign fire     = evb.evb_cmd_request & ~evb.evb_cmd_finish;
  assign is_write = fire && (wmask != EVB_MASK_DUMMY);

  always_comb begin
    claim_word = '{valid: enc_valid, rsvd: '0, id: enc_id};
    claim_oh   = '0;
    w1c_clr    = '0;
    cmp_clr    = '0;
    if (fire && evb.evb_cmd_addr == ADDR_CLAIM && enc_valid)
      claim_oh = NUM_IRQ'(1) << enc_id;
    if (is_write && evb.evb_cmd_addr == ADDR_PEND)
      w1c_clr = NUM_IRQ'(evb_bmask(wmask) & evb_align(wmask, wdata));
    if (is_write && evb.evb_cmd_addr == ADDR_COMPLETE && 32'(cmp_id) < NUM_IRQ)
      cmp_clr = NUM_IRQ'(1) << cmp_id;
    // Edge sources: a new edge beats a same-cycle W1C or claim clear.
    // Level sources simply follow the registered active level.
    pend_nxt = (mode & ((pend & ~(w1c_clr | claim_oh)) | edge_set)) | (~mode & act);
    insv_nxt = (insv & ~cmp_clr) | claim_oh;
  end

  always_comb begin
    rdata = '0;
    case (evb.evb_cmd_addr)
      ADDR_PEND:     rdata = 32'(pend);
      ADDR_MASK:     rdata = 32'(mask);
      ADDR_MODE:     rdata = 32'(mode);
      ADDR_POL:      rdata = 32'(pol);
      ADDR_CLAIM:    rdata = claim_word;
      ADDR_INSV:     rdata = 32'(insv);
      ADDR_GPIO_OUT: rdata = 32'(gpio_out);
      ADDR_GPIO_IN:  rdata = 32'(gpio_in);
      default:       rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend                <= '0;
      insv                <= '0;
      mask                <= NUM_IRQ'(MASK_RST);
      mode                <= '1;
      pol                 <= '0;
      act_d1              <= '1;
      gpio_out            <= '0;
      mp_int              <= 1'b0;
      evb.evb_cmd_finish  <= 1'b0;
      evb.evb_cmd_rd_data <= '0;
    end else begin
      act_d1             <= act;
      pend               <= pend_nxt;
      insv               <= insv_nxt;
      mp_int             <= |elig;
      evb.evb_cmd_finish <= fire;
      if (fire) evb.evb_cmd_rd_data <= rdata;
      if (is_write) begin
        case (evb.evb_cmd_addr)
          ADDR_MASK:     mask     <= NUM_IRQ'(evb_merge(32'(mask), wmask, wdata));
          ADDR_MODE:     mode     <= NUM_IRQ'(evb_merge(32'(mode), wmask, wdata));
          ADDR_POL:      pol      <= NUM_IRQ'(evb_merge(32'(pol), wmask, wdata));
          ADDR_GPIO_OUT: gpio_out <= NUM_GPIO'(evb_merge(32'(gpio_out), wmask, wdata));
          default:       ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pic_prio.sv
// Directed bench for pic_prio: capture, priority claim/complete, W1C races,
// GPIO byte-lane writes, handshake spacing and reset abort.
module tb_pic_prio;
  import pic_prio_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] int_src = '0;
  logic [31:0] gpio_in = '0;
  logic [31:0] gpio_out;
  logic        mp_int;
  logic [31:0] r;
  int          n_checks = 0;
  int          n_errors = 0;
  int          pulses, adjacent;
  logic        prev_fin;

  pic_prio_if evb();

  pic_prio #(.NUM_IRQ(32), .NUM_GPIO(32), .MASK_RST(32'h0000_00FF)) dut (
    .clk      (clk),
    .rst      (rst),
    .int_src  (int_src),
    .mp_int   (mp_int),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .evb      (evb)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_xfer(input logic [3:0] a, input logic [1:0] m, input logic [31:0] d,
                          output logic [31:0] rd);
    bit done = 1'b0;
    evb.evb_cmd_request = 1'b1;
    evb.evb_cmd_addr    = a;
    evb.evb_cmd_wr_mask = m;
    evb.evb_cmd_wr_data = d;
    for (int i = 0; i < 16 && !done; i++) begin
      @(posedge clk);
      #1;
      if (evb.evb_cmd_finish) done = 1'b1;
    end
    rd = evb.evb_cmd_rd_data;
    evb.evb_cmd_request = 1'b0;
    if (!done) chk_val("bus_timeout", 32'd0, 32'd1);
  endtask

  task automatic bus_rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    bus_xfer(a, EVB_MASK_DUMMY, 32'h0, rd);
    chk_val(tag, rd, exp);
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [1:0] m, input logic [31:0] d);
    logic [31:0] rd;
    bus_xfer(a, m, d, rd);
  endtask

  initial begin
    evb.evb_cmd_request = 1'b0;
    evb.evb_cmd_addr    = '0;
    evb.evb_cmd_wr_mask = '0;
    evb.evb_cmd_wr_data = '0;
    tick(3);
    chk_val("rst_mp_int", 32'(mp_int), 32'd0);
    chk_val("rst_finish", 32'(evb.evb_cmd_finish), 32'd0);
    chk_val("rst_rd_data", evb.evb_cmd_rd_data, 32'd0);
    chk_val("rst_gpio_out", gpio_out, 32'd0);
    rst = 1'b0;
    tick(1);
    bus_rd("rst_pend", ADDR_PEND, 32'h0);
    bus_rd("rst_mask", ADDR_MASK, 32'h0000_00FF);
    bus_rd("rst_mode", ADDR_MODE, 32'hFFFF_FFFF);
    bus_rd("rst_pol",  ADDR_POL,  32'h0);
    bus_rd("rst_insv", ADDR_INSV, 32'h0);

    // Edge on source 5: PEND next cycle, mp_int one cycle later
    int_src[5] = 1'b1;
    tick(1);
    chk_val("irq5_mp_early", 32'(mp_int), 32'd0);
    tick(1);
    chk_val("irq5_mp_2cyc", 32'(mp_int), 32'd1);
    bus_rd("irq5_pend", ADDR_PEND, 32'h0000_0020);
    bus_rd("irq5_claim", ADDR_CLAIM, 32'h8000_0005);
    tick(1);
    chk_val("irq5_mp_claimed", 32'(mp_int), 32'd0);
    bus_wr(ADDR_COMPLETE, EVB_MASK_W, 32'd5);
    int_src[5] = 1'b0;
    bus_rd("irq5_insv_done", ADDR_INSV, 32'h0);

    // Sources 3 and 9: lowest index claimed first
    bus_wr(ADDR_MASK, EVB_MASK_W, 32'h0000_02FF);
    int_src[3] = 1'b1;
    int_src[9] = 1'b1;
    tick(2);
    bus_rd("p39_pend", ADDR_PEND, 32'h0000_0208);
    bus_rd("p39_claim3", ADDR_CLAIM, 32'h8000_0003);
    bus_rd("p39_insv3", ADDR_INSV, 32'h0000_0008);
    bus_rd("p39_pend_after", ADDR_PEND, 32'h0000_0200);
    chk_val("p39_mp_int", 32'(mp_int), 32'd1);
    bus_wr(ADDR_COMPLETE, EVB_MASK_W, 32'd3);
    bus_rd("p39_insv_cmp3", ADDR_INSV, 32'h0);
    bus_wr(ADDR_COMPLETE, EVB_MASK_W, 32'd40);
    bus_rd("p39_claim9", ADDR_CLAIM, 32'h8000_0009);
    bus_wr(ADDR_COMPLETE, EVB_MASK_DUMMY, 32'd9);
    bus_rd("p39_insv_dummy", ADDR_INSV, 32'h0000_0200);
    bus_wr(ADDR_COMPLETE, EVB_MASK_L, 32'd9);
    bus_rd("p39_claim_empty", ADDR_CLAIM, 32'h0);
    bus_rd("p39_insv_empty", ADDR_INSV, 32'h0);
    int_src[3] = 1'b0;
    int_src[9] = 1'b0;

    // Source 2 as active-low level
    bus_wr(ADDR_MODE, EVB_MASK_W, 32'hFFFF_FFFB);
    bus_wr(ADDR_POL, EVB_MASK_W, 32'h0000_0004);
    tick(2);
    bus_rd("lvl2_pend", ADDR_PEND, 32'h0000_0004);
    chk_val("lvl2_mp_int", 32'(mp_int), 32'd1);
    bus_wr(ADDR_PEND, EVB_MASK_W, 32'h0000_0004);
    bus_rd("lvl2_pend_w1c", ADDR_PEND, 32'h0000_0004);
    bus_rd("lvl2_claim", ADDR_CLAIM, 32'h8000_0002);
    bus_rd("lvl2_pend_claim", ADDR_PEND, 32'h0000_0004);
    bus_rd("lvl2_insv", ADDR_INSV, 32'h0000_0004);
    bus_wr(ADDR_COMPLETE, EVB_MASK_W, 32'd2);
    int_src[2] = 1'b1;
    tick(2);
    bus_rd("lvl2_pend_off", ADDR_PEND, 32'h0);
    chk_val("lvl2_mp_off", 32'(mp_int), 32'd0);

    // Source 7: edge set beats a same-cycle W1C
    int_src[7] = 1'b1;
    tick(2);
    bus_rd("e7_pend", ADDR_PEND, 32'h0000_0080);
    int_src[7] = 1'b0;
    tick(1);
    int_src[7] = 1'b1;
    bus_wr(ADDR_PEND, EVB_MASK_W, 32'h0000_0080);
    bus_rd("e7_set_wins", ADDR_PEND, 32'h0000_0080);
    bus_wr(ADDR_PEND, EVB_MASK_H, 32'h0000_0080);
    bus_rd("e7_w1c_hlane", ADDR_PEND, 32'h0000_0080);
    bus_wr(ADDR_PEND, EVB_MASK_L, 32'h0000_0080);
    bus_rd("e7_w1c_clear", ADDR_PEND, 32'h0);
    chk_val("e7_mp_off", 32'(mp_int), 32'd0);

    // GPIO and lane-masked writes
    bus_wr(ADDR_GPIO_OUT, EVB_MASK_W, 32'h1234_5678);
    chk_val("gpio_w", gpio_out, 32'h1234_5678);
    bus_xfer(ADDR_GPIO_OUT, EVB_MASK_H, 32'h0000_ABCD, r);
    chk_val("gpio_rd_before_wr", r, 32'h1234_5678);
    chk_val("gpio_h", gpio_out, 32'hABCD_5678);
    bus_wr(ADDR_GPIO_OUT, EVB_MASK_L, 32'h0000_1111);
    chk_val("gpio_l", gpio_out, 32'hABCD_1111);
    bus_xfer(ADDR_GPIO_OUT, EVB_MASK_DUMMY, 32'hFFFF_FFFF, r);
    chk_val("gpio_dummy_rd", r, 32'hABCD_1111);
    chk_val("gpio_dummy", gpio_out, 32'hABCD_1111);
    gpio_in = 32'hCAFE_BABE;
    bus_rd("gpio_in", ADDR_GPIO_IN, 32'hCAFE_BABE);
    bus_wr(4'd12, EVB_MASK_W, 32'hFFFF_FFFF);
    bus_rd("addr12_zero", 4'd12, 32'h0);
    bus_wr(ADDR_MASK, EVB_MASK_H, 32'h0000_8000);
    bus_rd("mask_h", ADDR_MASK, 32'h8000_02FF);

    // Request held high: every accepted access is followed by a finish-low cycle
    tick(1);
    pulses   = 0;
    adjacent = 0;
    prev_fin = 1'b0;
    evb.evb_cmd_request = 1'b1;
    evb.evb_cmd_addr    = ADDR_GPIO_IN;
    evb.evb_cmd_wr_mask = EVB_MASK_DUMMY;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (evb.evb_cmd_finish) pulses++;
      if (evb.evb_cmd_finish && prev_fin) adjacent++;
      prev_fin = evb.evb_cmd_finish;
    end
    evb.evb_cmd_request = 1'b0;
    chk_val("b2b_pulses", 32'(pulses), 32'd4);
    chk_val("b2b_adjacent", 32'(adjacent), 32'd0);
    tick(1);

    // Reset in the middle of an access, with lines still active
    int_src[4] = 1'b1;
    tick(2);
    bus_rd("rst_pre_claim", ADDR_CLAIM, 32'h8000_0004);
    rst = 1'b1;
    evb.evb_cmd_request = 1'b1;
    evb.evb_cmd_addr    = ADDR_MASK;
    evb.evb_cmd_wr_mask = EVB_MASK_W;
    evb.evb_cmd_wr_data = 32'h0;
    tick(1);
    chk_val("abort_finish0", 32'(evb.evb_cmd_finish), 32'd0);
    evb.evb_cmd_request = 1'b0;
    tick(1);
    chk_val("abort_finish1", 32'(evb.evb_cmd_finish), 32'd0);
    rst = 1'b0;
    tick(1);
    chk_val("abort_rd_data", evb.evb_cmd_rd_data, 32'h0);
    chk_val("abort_gpio_out", gpio_out, 32'h0);
    tick(1);
    bus_rd("abort_pend", ADDR_PEND, 32'h0);
    bus_rd("abort_mask", ADDR_MASK, 32'h0000_00FF);
    bus_rd("abort_mode", ADDR_MODE, 32'hFFFF_FFFF);
    bus_rd("abort_pol",  ADDR_POL,  32'h0);
    bus_rd("abort_insv", ADDR_INSV, 32'h0);
    chk_val("abort_mp_int", 32'(mp_int), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pic_prio.md
PIC_PRIO -- requirements
Module: pic_prio

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 32, number of interrupt sources, legal range 1..32.
REQ-002 SHALL have parameter NUM_GPIO, default 16, GPIO width, legal range 1..32.
REQ-003 SHALL have parameter MASK_RST, default 32'h000000FF, reset value of MASK; bits at and above NUM_IRQ are forced to 0.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on the rising edge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port int_src, input, NUM_IRQ, raw interrupt lines, already synchronous to clk.
REQ-007 SHALL have port mp_int, output, 1, interrupt request to the processor.
REQ-008 SHALL have port gpio_in, input, NUM_GPIO, general-purpose inputs.
REQ-009 SHALL have port gpio_out, output, NUM_GPIO, registered general-purpose outputs.
REQ-010 SHALL have EVB slave ports: evb_cmd_request in 1, evb_cmd_addr in 4, evb_cmd_wr_mask in 2, evb_cmd_wr_data in 32, evb_cmd_finish out 1 (registered), evb_cmd_rd_data out 32 (registered).

Function
REQ-011 Per-source active level SHALL be int_src[i] XOR POL[i].
REQ-012 An edge source (MODE[i]=1) SHALL set PEND[i] in the cycle after its active level rises, using a one-cycle-delayed copy of the active level.
REQ-013 A level source (MODE[i]=0) SHALL have PEND[i] equal to its registered active level; software clear and claim SHALL NOT affect it.
REQ-014 When an edge set and a clear (W1C or claim) hit the same bit in the same cycle, the set SHALL win.
REQ-015 ELIG SHALL be PEND & MASK & ~INSV; mp_int SHALL be the registered OR of ELIG, so it asserts 2 cycles after the input edge.
REQ-016 The highest-priority source SHALL be the lowest set index of ELIG.
REQ-017 Register map (evb_cmd_addr): 0 PEND R/W1C; 1 MASK RW; 2 MODE RW, 1=edge; 3 POL RW, 1=active-low; 4 CLAIM R; 5 COMPLETE W; 6 INSV R; 7 GPIO_OUT RW; 8 GPIO_IN R; 9-15 read 0, writes ignored.
REQ-018 Write data by mask: W = wr_data[31:0]; H = wr_data[15:0] into bits 31:16; L = wr_data[15:0] into bits 15:0; DUMMY = no write, read only.
REQ-019 Bits at or above NUM_IRQ or NUM_GPIO SHALL read 0 and ignore writes.
REQ-020 A CLAIM read SHALL return {valid, 26'b0, id[4:0]} for the highest-priority source, set INSV[id], and clear PEND[id] if that source is edge-mode.
REQ-021 A CLAIM read with ELIG=0 SHALL return 0 and change no state.
REQ-022 A COMPLETE write SHALL clear INSV[wr_data[4:0]]; an id that is not in service or is >= NUM_IRQ SHALL be ignored; the wr_mask value is irrelevant for this register, except that DUMMY performs no write.
REQ-023 Handshake: a request sampled while evb_cmd_finish=0 SHALL be executed, and evb_cmd_finish SHALL pulse high for exactly 1 cycle on the next cycle, together with rd_data.
REQ-024 While evb_cmd_finish=1, a request SHALL be ignored; the requester holds request until it sees finish.
REQ-025 rd_data SHALL return the register value before any write in the same access, including for RW registers.
REQ-026 Interrupt capture (REQ-012/013) SHALL continue every cycle, independent of bus activity.

Reset
REQ-027 On rst: PEND=0, INSV=0, MASK=MASK_RST, MODE=all ones, POL=0, gpio_out=0, evb_cmd_finish=0, evb_cmd_rd_data=0, mp_int=0.
REQ-028 On rst, the delayed active-level copy SHALL be set to all ones, so a line already active at reset raises no edge.
REQ-029 rst SHALL abort an in-flight access, with no finish pulse.

Structure
REQ-030 EVB_MASK_W/H/L/DUMMY encodings, register-address constants and the CLAIM field layout SHALL live in the shared defines package.
REQ-031 The priority select SHALL be a sub-module pic_prio_enc, parametrised by width, with outputs valid and id.

Verification
REQ-032 Rising edge on int_src[5], MASK bit 5 set -> PEND=0x20, mp_int high 2 cycles later.
REQ-033 Sources 3 and 9 pending, read CLAIM -> rd_data=0x80000003, INSV=0x8, PEND=0x200; write COMPLETE 3 -> INSV=0.
REQ-034 MODE[2]=0, POL[2]=1, int_src[2] low -> PEND[2]=1; W1C PEND bit 2 -> stays 1; int_src[2] high -> 0.
REQ-035 W1C of bit 7 in the same cycle as a new edge on source 7 -> PEND[7]=1.
REQ-036 GPIO_OUT=0x12345678, then write mask H, data 0xABCD -> gpio_out=0xABCD5678 (NUM_GPIO=32); back-to-back requests -> finish pulses separated by at least 1 low cycle.
REQ-037 rst asserted during an access -> no finish pulse, all registers at their REQ-027 values.
